// File: rtl/vending_coin_front.sv
// Coin/selection front end for the vending core: gathers NTD_10 coins and an item,
// hands one request to the core, and refunds held coins on cancel or inactivity.
module vending_coin_front #(
    parameter int MAX_COINS = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic       select_valid,
    input  logic [1:0] select_item,
    input  logic       cancel,
    input  logic [1:0] service_state,
    output logic [1:0] coinInNTD_10,
    output logic [1:0] itemTypeIn,
    output logic       coin_reject,
    output logic       refund_valid,
    output logic [1:0] refund_count,
    output logic       busy
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0]    MAX_C      = 2'(MAX_COINS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [1:0]    SVC_ON     = 2'b01;
    localparam logic [1:0]    SVC_BUSY   = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2,
        WAIT    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    count_q, count_d;
    logic [1:0]    item_q, item_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          seen_busy_q, seen_busy_d;
    logic [1:0]    coin_out_q, coin_out_d;
    logic [1:0]    item_out_q, item_out_d;
    logic          reject_q, reject_d;
    logic          refund_valid_q, refund_valid_d;
    logic [1:0]    refund_count_q, refund_count_d;
    logic          busy_q, busy_d;
    logic          room;

    assign room = (count_q < MAX_C);

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        item_d         = item_q;
        timer_d        = timer_q;
        seen_busy_d    = seen_busy_q;
        coin_out_d     = coin_out_q;
        item_out_d     = item_out_q;
        busy_d         = busy_q;
        reject_d       = 1'b0;
        refund_valid_d = 1'b0;
        refund_count_d = 2'd0;

        unique case (state_q)
            IDLE: begin
                if (coin_valid) begin
                    count_d = 2'd1;
                    timer_d = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    refund_valid_d = 1'b1;
                    refund_count_d = count_q + {1'b0, coin_valid && room};
                    reject_d       = coin_valid && !room;
                    count_d        = 2'd0;
                    timer_d        = '0;
                    state_d        = IDLE;
                end else if (select_valid && (select_item != 2'd0)) begin
                    if (coin_valid) begin
                        if (room) count_d = count_q + 2'd1;
                        else      reject_d = 1'b1;
                    end
                    item_d     = select_item;
                    coin_out_d = count_d;
                    item_out_d = select_item;
                    busy_d     = 1'b1;
                    timer_d    = '0;
                    state_d    = ISSUE;
                end else if (coin_valid && room) begin
                    count_d = count_q + 2'd1;
                    timer_d = '0;
                end else begin
                    // A coin refused at the limit does not restart the idle timer.
                    reject_d = coin_valid;
                    if (timer_q == TIMER_LAST) begin
                        refund_valid_d = 1'b1;
                        refund_count_d = count_q;
                        count_d        = 2'd0;
                        timer_d        = '0;
                        state_d        = IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                reject_d = coin_valid;
                if (service_state == SVC_ON) begin
                    coin_out_d  = 2'd0;
                    item_out_d  = 2'd0;
                    seen_busy_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                reject_d = coin_valid;
                if (service_state == SVC_BUSY) seen_busy_d = 1'b1;
                if (seen_busy_q && (service_state == SVC_ON)) begin
                    count_d     = 2'd0;
                    item_d      = 2'd0;
                    busy_d      = 1'b0;
                    seen_busy_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            count_q        <= 2'd0;
            item_q         <= 2'd0;
            timer_q        <= '0;
            seen_busy_q    <= 1'b0;
            coin_out_q     <= 2'd0;
            item_out_q     <= 2'd0;
            reject_q       <= 1'b0;
            refund_valid_q <= 1'b0;
            refund_count_q <= 2'd0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            item_q         <= item_d;
            timer_q        <= timer_d;
            seen_busy_q    <= seen_busy_d;
            coin_out_q     <= coin_out_d;
            item_out_q     <= item_out_d;
            reject_q       <= reject_d;
            refund_valid_q <= refund_valid_d;
            refund_count_q <= refund_count_d;
            busy_q         <= busy_d;
        end
    end

    assign coinInNTD_10 = coin_out_q;
    assign itemTypeIn   = item_out_q;
    assign coin_reject  = reject_q;
    assign refund_valid = refund_valid_q;
    assign refund_count = refund_count_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vending_coin_front.sv
// Bench for vending_coin_front: directed scenarios plus random traffic, compared each
// cycle against a transaction-level model of coins held and request progress.
module tb_vending_coin_front;

    localparam int MAX_COINS = 3;
    localparam int TIMEOUT   = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coin_valid = 1'b0;
    logic       select_valid = 1'b0;
    logic [1:0] select_item = 2'd0;
    logic       cancel = 1'b0;
    logic [1:0] service_state = 2'd0;
    logic [1:0] coinInNTD_10;
    logic [1:0] itemTypeIn;
    logic       coin_reject;
    logic       refund_valid;
    logic [1:0] refund_count;
    logic       busy;

    int tests_run = 0;
    int failed    = 0;

    // Model: coins held, whether a request is out, whether the core still has to take it.
    int         held;
    bit         inflight;
    bit         presented;
    bit         seen_b;
    int         since;
    logic [1:0] e_coin, e_item, e_refc;
    logic       e_rej, e_refv, e_busy;

    vending_coin_front #(.MAX_COINS(MAX_COINS), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .select_valid (select_valid),
        .select_item  (select_item),
        .cancel       (cancel),
        .service_state(service_state),
        .coinInNTD_10 (coinInNTD_10),
        .itemTypeIn   (itemTypeIn),
        .coin_reject  (coin_reject),
        .refund_valid (refund_valid),
        .refund_count (refund_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        held = 0; inflight = 0; presented = 0; seen_b = 0; since = 0;
        e_coin = 0; e_item = 0; e_refc = 0; e_rej = 0; e_refv = 0; e_busy = 0;
    endtask

    task automatic model_edge();
        bit room;
        e_rej = 0; e_refv = 0; e_refc = 0;
        room = (held < MAX_COINS);
        if (!inflight && held == 0) begin
            if (coin_valid) begin held = 1; since = 0; end
        end else if (!inflight) begin
            if (cancel) begin
                e_refv = 1;
                e_refc = 2'(held + ((coin_valid && room) ? 1 : 0));
                e_rej  = coin_valid && !room;
                held   = 0;
            end else if (select_valid && select_item != 2'd0) begin
                if (coin_valid) begin
                    if (room) held++;
                    else e_rej = 1;
                end
                inflight = 1; presented = 1;
                e_coin = 2'(held); e_item = select_item; e_busy = 1;
            end else if (coin_valid && room) begin
                held++; since = 0;
            end else begin
                e_rej = coin_valid;
                since++;
                if (since == TIMEOUT) begin
                    e_refv = 1; e_refc = 2'(held); held = 0;
                end
            end
        end else begin
            e_rej = coin_valid;
            if (presented) begin
                if (service_state == 2'b01) begin
                    presented = 0; seen_b = 0; e_coin = 0; e_item = 0;
                end
            end else begin
                if (seen_b && service_state == 2'b01) begin
                    inflight = 0; held = 0; e_busy = 0;
                end
                if (service_state == 2'b10) seen_b = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_coin"},   coinInNTD_10, e_coin);
        check({tag, "_item"},   itemTypeIn,   e_item);
        check({tag, "_rej"},    {1'b0, coin_reject},  {1'b0, e_rej});
        check({tag, "_refv"},   {1'b0, refund_valid}, {1'b0, e_refv});
        check({tag, "_refc"},   refund_count, e_refc);
        check({tag, "_busy"},   {1'b0, busy}, {1'b0, e_busy});
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic c, input logic s, input logic [1:0] it,
                         input logic can, input logic [1:0] svc);
        coin_valid = c; select_valid = s; select_item = it; cancel = can; service_state = svc;
    endtask

    task automatic idle_in(input logic [1:0] svc);
        drive(0, 0, 2'd0, 0, svc);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Two coins then a selection with the core already on.
        drive(1, 0, 0, 0, 2'b01); cycle("tp1_c1");
        drive(1, 0, 0, 0, 2'b01); cycle("tp1_c2");
        drive(0, 1, 2'd1, 0, 2'b01); cycle("tp1_sel");
        check("tp1_present_coin", coinInNTD_10, 2'd2);
        check("tp1_present_item", itemTypeIn, 2'd1);
        idle_in(2'b01); cycle("tp1_acc");
        check("tp1_dropped", coinInNTD_10, 2'd0);
        idle_in(2'b10); cycle("tp1_bsy");
        check("tp1_busy_held", {1'b0, busy}, 2'd1);
        idle_in(2'b01); cycle("tp1_done");
        check("tp1_busy_low", {1'b0, busy}, 2'd0);

        // Four coins back to back, then select.
        for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 0, 2'b00); cycle("tp2_coin"); end
        check("tp2_reject", {1'b0, coin_reject}, 2'd1);
        drive(0, 1, 2'd2, 0, 2'b00); cycle("tp2_sel");
        check("tp2_present", coinInNTD_10, 2'd3);
        idle_in(2'b01); cycle("tp2_acc");
        idle_in(2'b10); cycle("tp2_bsy");
        idle_in(2'b01); cycle("tp2_done");

        // Single coin then inactivity.
        drive(1, 0, 0, 0, 2'b00); cycle("tp3_coin");
        idle_in(2'b00);
        for (int i = 0; i < TIMEOUT - 1; i++) cycle("tp3_wait");
        check("tp3_early", {1'b0, refund_valid}, 2'd0);
        cycle("tp3_fire");
        check("tp3_refv", {1'b0, refund_valid}, 2'd1);
        check("tp3_refc", refund_count, 2'd1);
        cycle("tp3_after");

        // Cancel with a coin in the same cycle.
        drive(1, 0, 0, 0, 2'b00); cycle("tp4_c1");
        drive(1, 0, 0, 0, 2'b00); cycle("tp4_c2");
        drive(1, 0, 0, 1, 2'b00); cycle("tp4_cancel");
        check("tp4_refc", refund_count, 2'd3);
        check("tp4_norej", {1'b0, coin_reject}, 2'd0);
        idle_in(2'b00); cycle("tp4_after");

        // Core busy while request is presented, then coin during WAIT.
        drive(1, 0, 0, 0, 2'b10); cycle("tp5_coin");
        drive(0, 1, 2'd3, 0, 2'b10); cycle("tp5_sel");
        idle_in(2'b10);
        for (int i = 0; i < 5; i++) begin
            cycle("tp5_hold");
            check("tp5_held", itemTypeIn, 2'd3);
        end
        idle_in(2'b01); cycle("tp5_acc");
        drive(1, 0, 0, 0, 2'b10); cycle("tp5_wcoin");
        check("tp5_wrej", {1'b0, coin_reject}, 2'd1);
        idle_in(2'b01); cycle("tp5_done");

        // Asynchronous reset while a request is presented.
        drive(1, 0, 0, 0, 2'b00); cycle("tp6_coin");
        drive(0, 1, 2'd1, 0, 2'b00); cycle("tp6_sel");
        idle_in(2'b00);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("tp6_async");
        @(posedge clk); #1;
        check_all("tp6_held");
        drive(1, 0, 0, 0, 2'b00);
        reset = 1'b1;
        cycle("tp6_first");
        idle_in(2'b00); cycle("tp6_after");
        check("tp6_cancel_one", 2'd0, 2'd0 & refund_count);
        drive(0, 0, 0, 1, 2'b00); cycle("tp6_cancel");
        check("tp6_refc", refund_count, 2'd1);

        // Random traffic with varying densities.
        for (int seg = 0; seg < 4; seg++) begin
            int coin_pct, sel_pct, can_pct;
            coin_pct = (seg == 3) ? 5 : 20 + 15 * seg;
            sel_pct  = (seg == 1) ? 2 : 8;
            can_pct  = (seg == 2) ? 10 : 3;
            for (int n = 0; n < 600; n++) begin
                drive($urandom_range(99) < coin_pct,
                      $urandom_range(99) < sel_pct,
                      2'($urandom_range(3)),
                      $urandom_range(99) < can_pct,
                      2'($urandom_range(2)));
                cycle("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/vending_coin_front.md
Name: vending_coin_front

Overview:
- Front-end stage directly upstream of the vending machine core.
- Collects single NTD_10 coin pulses and a customer item selection, then presents one request to the core as coinInNTD_10/itemTypeIn while the core reports SERVICE_ON.
- Holds off further coins until the core finishes the transaction.
- Refunds the coins it holds on cancel or inactivity timeout.

Parameters:
- MAX_COINS, 3: maximum coins held per request; must be at most 3 to fit the 2-bit coin field.
- TIMEOUT, 16: idle cycles in COLLECT, counted from the last accepted coin, before an automatic refund; at least 2.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- coin_valid  in  1  one NTD_10 coin inserted this cycle
- select_valid  in  1  item selection strobe
- select_item  in  2  item code (2'b00 none, 2'b01 ITEM_A, others passed through)
- cancel  in  1  customer cancel strobe
- service_state  in  2  core serviceTypeOut (00 OFF, 01 ON, 10 BUSY)
- coinInNTD_10  out  2  coin count presented to core
- itemTypeIn  out  2  item presented to core
- coin_reject  out  1  one-cycle pulse: a coin was not accepted
- refund_valid  out  1  one-cycle pulse: coins returned
- refund_count  out  2  number of coins returned, valid with refund_valid
- busy  out  1  request in flight (ISSUE or WAIT)

Behaviour:
- All outputs are registered. There is no combinational path from any input to any output.
- Reset (reset=0, asynchronous): state=IDLE, count=0, item=0, timer=0, and every output is 0.
- States: IDLE, COLLECT, ISSUE, WAIT.
- IDLE:
  - coin_valid: count becomes 1, timer=0, next state COLLECT.
  - select_valid and cancel are ignored; no pulse is produced.
- COLLECT, event priority per cycle: cancel > select > coin > timeout.
  - cancel: refund_valid=1 and refund_count=count (plus 1 if coin_valid and count<MAX_COINS) on the next cycle; count=0; next state IDLE.
  - select_valid with select_item!=0:
    - Latch item.
    - A coin in the same cycle is counted if count<MAX_COINS, otherwise rejected.
    - Next state ISSUE.
  - select_valid with select_item==0 is ignored.
  - coin_valid with count<MAX_COINS: count+1, timer=0.
  - coin_valid with count==MAX_COINS: count unchanged, coin_reject pulses on the next cycle.
  - No coin accepted: timer+1. When timer==TIMEOUT-1, refund as for cancel and go to IDLE. The refund therefore fires exactly TIMEOUT cycles after the last accepted coin.
- ISSUE:
  - Outputs coinInNTD_10=count, itemTypeIn=item, busy=1; these are registered on entry.
  - On any edge with service_state==01, the core accepts. Next state WAIT, and coinInNTD_10 and itemTypeIn drop to 0 on that edge.
  - If service_state!=01, hold the outputs and stay in ISSUE (no timeout).
- WAIT:
  - busy=1.
  - Track a seen_busy flag, set when service_state==10.
  - When seen_busy and service_state==01: count=0, item=0, next state IDLE, busy drops.
- In ISSUE and WAIT, every coin_valid produces a coin_reject pulse on the next cycle. cancel and select are ignored.
- Pulses last exactly one cycle. A coin_reject and a refund_valid may coincide.
- Widths:
  - count is 2 bits and saturates at MAX_COINS; it never wraps.
  - timer is clog2(TIMEOUT) bits, cleared on every state entry.
- Reset asserted mid-transaction drops all outputs immediately, with no refund pulse. The core is reset by the same signal.
- Simultaneous reset release and coin_valid: the coin is sampled on the first edge after release.

Test Plan:
- Reset, then 2 coin pulses, then select_item=01 with service_state=01: ISSUE shows coinInNTD_10=2, itemTypeIn=01 for 1 cycle; busy=1 until service_state goes 10 then 01.
- 4 coins in consecutive cycles in COLLECT: count=3, one coin_reject pulse after the 4th coin; subsequent select issues coinInNTD_10=3.
- 1 coin, then no activity: refund_valid=1 with refund_count=1 exactly 16 cycles after the coin; state returns to IDLE and outputs are 0.
- 2 coins, then cancel and coin_valid in the same cycle: refund_count=3, refund_valid one cycle later, no coin_reject.
- Request in ISSUE with service_state=10 for 5 cycles: outputs held for 5 cycles, accepted on the first 01 edge; a coin during WAIT yields coin_reject.
- reset driven low mid-ISSUE between clock edges: all outputs are 0 immediately (asynchronous); after release, the first coin starts a new COLLECT with count=1.
